// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (00.00 .. 59.99, wrapping) driven by active-low start/stop and clear keys.
// Optional lap-hold display mode is built when BCD_STOPWATCH_LAP_EN is defined.

module bcd_key_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   logic sync1;
   logic sync2;
   logic prev;

   // NOTE: sequential state uses non-blocking assignments only; the flops reset to the released (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign press = prev & ~sync2;

endmodule

module bcd_stopwatch #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_start_stop_n,
   input  logic        key_clear_n,
`ifdef BCD_STOPWATCH_LAP_EN
   input  logic        key_lap_n,
`endif
   output logic [15:0] data_out,
   output logic        running
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE
`ifdef BCD_STOPWATCH_LAP_EN
      , ST_LAP
`endif
   } state_t;

   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
   } count_t;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] pre_q;
   count_t        cnt_q;
   count_t        cnt_d;
   logic          ss_press;
   logic          clr_press;
   logic          counting;
   logic          tick;
   logic          do_clear;
   logic          start_from_idle;

   bcd_key_sync u_sync_ss (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_start_stop_n),
      .press (ss_press)
   );

   bcd_key_sync u_sync_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_clear_n),
      .press (clr_press)
   );

`ifdef BCD_STOPWATCH_LAP_EN
   logic lap_press;

   bcd_key_sync u_sync_lap (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_lap_n),
      .press (lap_press)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (ss_press) state_d = ST_RUN;
         ST_RUN: begin
            if (ss_press) state_d = ST_PAUSE;
`ifdef BCD_STOPWATCH_LAP_EN
            else if (lap_press) state_d = ST_LAP;
`endif
         end
         // Clear outranks start/stop when both arrive together while paused.
         ST_PAUSE: begin
            if (clr_press)     state_d = ST_IDLE;
            else if (ss_press) state_d = ST_RUN;
         end
`ifdef BCD_STOPWATCH_LAP_EN
         ST_LAP: begin
            if (ss_press)       state_d = ST_PAUSE;
            else if (lap_press) state_d = ST_RUN;
         end
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      running = 1'b0;
      case (state_q)
         ST_RUN:  running = 1'b1;
`ifdef BCD_STOPWATCH_LAP_EN
         ST_LAP:  running = 1'b1;
`endif
         default: running = 1'b0;
      endcase
   end

   assign counting        = running;
   assign tick            = counting && (pre_q == PRE_MAX);
   assign do_clear        = (state_q == ST_PAUSE) && clr_press;
   assign start_from_idle = (state_q == ST_IDLE) && ss_press;

   // Prescaler holds its value while paused so a resume finishes the partial interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (do_clear || start_from_idle) begin
         pre_q <= '0;
      end else if (counting) begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (do_clear) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q.d0 != 4'd9) begin
            cnt_d.d0 = cnt_q.d0 + 4'd1;
         end else begin
            cnt_d.d0 = 4'd0;
            if (cnt_q.d1 != 4'd9) begin
               cnt_d.d1 = cnt_q.d1 + 4'd1;
            end else begin
               cnt_d.d1 = 4'd0;
               if (cnt_q.d2 != 4'd9) begin
                  cnt_d.d2 = cnt_q.d2 + 4'd1;
               end else begin
                  cnt_d.d2 = 4'd0;
                  cnt_d.d3 = (cnt_q.d3 == 4'd5) ? 4'd0 : cnt_q.d3 + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

`ifdef BCD_STOPWATCH_LAP_EN
   count_t lap_hold_q;

   // Captures the displayed count on the edge that enters the lap view.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_hold_q <= '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
         lap_hold_q <= cnt_q;
      end
   end

   assign data_out = (state_q == ST_LAP) ? lap_hold_q : cnt_q;
`else
   assign data_out = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch at PRESCALE = 10; lap checks compile in with BCD_STOPWATCH_LAP_EN.

module tb_bcd_stopwatch;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic        run;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        key_start_stop_n;
   logic        key_clear_n;
`ifdef BCD_STOPWATCH_LAP_EN
   logic        key_lap_n;
`endif
   logic [15:0] data_out;
   logic        running;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bcd_stopwatch #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .key_start_stop_n (key_start_stop_n),
      .key_clear_n      (key_clear_n),
`ifdef BCD_STOPWATCH_LAP_EN
      .key_lap_n        (key_lap_n),
`endif
      .data_out         (data_out),
      .running          (running)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act_d, input logic act_r,
                        input logic [15:0] exp_d, input logic exp_r);
      checks++;
      if (act_d !== exp_d || act_r !== exp_r) begin
         errors++;
         $display("FAIL %s: got data_out=%h running=%b, expected data_out=%h running=%b",
                  name, act_d, act_r, exp_d, exp_r);
      end
   endtask

   task automatic expect_out(input string name, input logic [15:0] d, input logic r);
      exp_t e;
      e.name = name;
      e.data = d;
      e.run  = r;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the DUT outputs whenever an expectation is posted.
   initial begin : monitor
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         e = exp_q.pop_front();
         check(e.name, data_out, running, e.data, e.run);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns one negedge before the state register reacts.
   task automatic press(input bit ss, input bit clr);
      key_start_stop_n = ~ss;
      key_clear_n      = ~clr;
      wait_cyc(2);
      key_start_stop_n = 1'b1;
      key_clear_n      = 1'b1;
   endtask

`ifdef BCD_STOPWATCH_LAP_EN
   task automatic press_lap();
      key_lap_n = 1'b0;
      wait_cyc(2);
      key_lap_n = 1'b1;
   endtask
`endif

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      expect_out("reset_state", 16'h0000, 1'b0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(1);
   endtask

   initial begin : stimulus
      rst_n            = 1'b1;
      key_start_stop_n = 1'b1;
      key_clear_n      = 1'b1;
`ifdef BCD_STOPWATCH_LAP_EN
      key_lap_n        = 1'b1;
`endif
      @(negedge clk);

      // Start latency, first ticks, full-range wrap
      do_reset();
      press(1'b1, 1'b0);
      expect_out("start_before_k2", 16'h0000, 1'b0);
      wait_cyc(1);
      expect_out("start_at_k2", 16'h0000, 1'b1);
      wait_cyc(9);
      expect_out("tick_not_yet", 16'h0000, 1'b1);
      wait_cyc(1);
      expect_out("first_tick", 16'h0001, 1'b1);
      wait_cyc(90);
      expect_out("ten_ticks", 16'h0010, 1'b1);
      wait_cyc(59890);
      expect_out("max_5999", 16'h5999, 1'b1);
      wait_cyc(10);
      expect_out("wrap_0000", 16'h0000, 1'b1);

      // Pause, partial-interval resume, clear ignored in RUN, clear in PAUSE
      do_reset();
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(1230);
      expect_out("reach_0123", 16'h0123, 1'b1);
      press(1'b1, 1'b0);
      wait_cyc(1);
      expect_out("pause_0123", 16'h0123, 1'b0);
      wait_cyc(500);
      expect_out("pause_hold_500", 16'h0123, 1'b0);
      press(1'b1, 1'b0);
      wait_cyc(1);
      expect_out("resume", 16'h0123, 1'b1);
      wait_cyc(6);
      expect_out("resume_partial_pre", 16'h0123, 1'b1);
      wait_cyc(1);
      expect_out("resume_partial_tick", 16'h0124, 1'b1);
      press(1'b0, 1'b1);
      wait_cyc(1);
      expect_out("clear_in_run_ignored", 16'h0124, 1'b1);
      wait_cyc(7);
      expect_out("run_after_clear", 16'h0125, 1'b1);
      press(1'b1, 1'b0);
      wait_cyc(1);
      expect_out("pause_0125", 16'h0125, 1'b0);
      press(1'b0, 1'b1);
      wait_cyc(1);
      expect_out("clear_in_pause", 16'h0000, 1'b0);
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(9);
      expect_out("restart_tick_pre", 16'h0000, 1'b1);
      wait_cyc(1);
      expect_out("restart_tick", 16'h0001, 1'b1);

      // Simultaneous presses
      press(1'b1, 1'b0);
      wait_cyc(1);
      expect_out("pause_0001", 16'h0001, 1'b0);
      press(1'b1, 1'b1);
      wait_cyc(1);
      expect_out("both_in_pause_idle", 16'h0000, 1'b0);
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(50);
      expect_out("reach_0005", 16'h0005, 1'b1);
      press(1'b1, 1'b1);
      wait_cyc(1);
      expect_out("both_in_run_pause", 16'h0005, 1'b0);
      wait_cyc(20);
      expect_out("both_in_run_hold", 16'h0005, 1'b0);

      // Asynchronous reset mid-count
      do_reset();
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(3470);
      expect_out("reach_0347", 16'h0347, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_reset", 16'h0000, 1'b0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(1);
      expect_out("post_reset_idle", 16'h0000, 1'b0);
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(9);
      expect_out("post_reset_tick_pre", 16'h0000, 1'b1);
      wait_cyc(1);
      expect_out("post_reset_tick", 16'h0001, 1'b1);

`ifdef BCD_STOPWATCH_LAP_EN
      // Lap hold and release
      do_reset();
      press(1'b1, 1'b0);
      wait_cyc(1);
      wait_cyc(2000);
      expect_out("reach_0200", 16'h0200, 1'b1);
      press_lap();
      wait_cyc(1);
      expect_out("lap_freeze", 16'h0200, 1'b1);
      wait_cyc(150);
      expect_out("lap_hold_150", 16'h0200, 1'b1);
      wait_cyc(150);
      expect_out("lap_hold_300", 16'h0200, 1'b1);
      press_lap();
      wait_cyc(1);
      expect_out("lap_release", 16'h0230, 1'b1);
      press_lap();
      wait_cyc(1);
      expect_out("lap_again", 16'h0230, 1'b1);
      wait_cyc(20);
      expect_out("lap_hold_20", 16'h0230, 1'b1);
      press(1'b1, 1'b0);
      wait_cyc(1);
      expect_out("lap_to_pause_live", 16'h0233, 1'b0);
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
